tx_feeder: RTL and testbench
============================

# tx_feeder

Byte buffer and launch sequencer directly upstream of the UART transmitter. Accepts bytes from the host side through a synchronous FIFO and presents them one at a time on the transmitter's parallel input, issuing a single-cycle start strobe per frame and pacing strobes so that no frame is launched while the previous one is still being serialised. Runs entirely in the transmitter clock domain.

## Interface

Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥2.
- FRAME_LEN, `FRAME_LEN` (11): transmitter cycles per frame (start + 8 data + parity + stop).
- IDLE_GAP, 1: extra idle (mark) cycles inserted between frames; ≥0.

Ports:
- TX_CLK  in  1  transmitter bit clock; all logic on rising edge.
- TX_RST_N  in  1  reset, asynchronous assert, active-low.
- WR_EN  in  1  write strobe; byte accepted on a rising edge with WR_EN=1 and FULL=0.
- WR_DATA  in  `DATA_WIDTH`  byte to enqueue.
- FULL  out  1  FIFO holds DEPTH entries.
- EMPTY  out  1  FIFO holds 0 entries.
- COUNT  out  $clog2(DEPTH)+1  current occupancy.
- OVERFLOW  out  1  one-cycle pulse when a write is dropped.
- BUSY  out  1  frame in flight (state BUSY).
- DATA_IN  out  `DATA_WIDTH`  byte to transmitter; held stable from its TX_START cycle until the next TX_START.
- TX_START  out  1  one-cycle launch strobe to transmitter.

## Operation

- FIFO: read/write pointers with extra wrap bit; FULL when pointers differ only in MSB, EMPTY when equal. Pointers wrap modulo DEPTH.
- Write with FULL=1 is dropped and OVERFLOW pulses, even if a pop occurs in the same cycle.
- Simultaneous write and pop on a non-full, non-empty FIFO: COUNT unchanged.
- Write to an empty FIFO and pop cannot coincide (pop requires EMPTY=0 registered).
- FSM states IDLE, BUSY; down-counter cnt, width $clog2(FRAME_LEN+IDLE_GAP).
- Launch condition L = (IDLE) or (BUSY and cnt==0), with EMPTY=0.
- On edge with L: pop head into DATA_IN register, TX_START←1, cnt←FRAME_LEN+IDLE_GAP−1, state←BUSY.
- BUSY, cnt≠0: cnt decrements, TX_START←0.
- BUSY, cnt==0, EMPTY=1: state←IDLE, TX_START←0.
- Reset mid-frame: all state cleared immediately; in-flight frame abandoned, FIFO contents discarded.

## Timing

- Reset values: FULL=0, EMPTY=1, COUNT=0, OVERFLOW=0, BUSY=0, DATA_IN=0, TX_START=0; pointers, cnt zero; state IDLE.
- All outputs registered or decoded from registers only; no combinational path from WR_* to outputs.
- Latency: byte written at edge k into empty FIFO while IDLE → TX_START=1 after edge k+1.
- Back-to-back spacing: successive TX_START rising edges exactly FRAME_LEN+IDLE_GAP cycles apart while FIFO non-empty.
- TX_START high exactly one cycle per frame; never two consecutive cycles.
- COUNT/FULL/EMPTY update on the edge of the accepted write or pop.

## Configuration

- `TX_FEEDER_ALMOST_FULL_EN`: when defined, adds parameter AF_LEVEL (default DEPTH−2) and output ALMOST_FULL (1 bit, reset 0), registered, high when COUNT ≥ AF_LEVEL after the current edge. When undefined, neither parameter nor port exists; all other behaviour identical.

## Structure

- `DATA_WIDTH` and new `FRAME_LEN` constant live in the shared uart_params.vh; transmitter frame length derives from the same constant.
- One sub-module: sync_fifo (storage, pointers, FULL/EMPTY/COUNT/OVERFLOW); tx_feeder holds FSM, counter, DATA_IN/TX_START registers.

## Test plan

- Reset released, no writes for 50 cycles → TX_START stays 0, EMPTY=1, DATA_IN=0.
- Write 0xA5 at edge k into idle block → TX_START=1 and DATA_IN=0xA5 after edge k+1; BUSY high 12 cycles (defaults); DATA_IN held.
- Burst-write 0x01..0x04 → four TX_START pulses spaced exactly 12 cycles, DATA_IN 0x01,0x02,0x03,0x04 in order, then IDLE.
- With launch blocked by an in-flight frame, write 9 bytes into DEPTH=8 → FULL after 8th, 9th dropped with OVERFLOW pulse, COUNT=8; simultaneous pop+write at COUNT=4 keeps COUNT=4.
- Assert TX_RST_N low mid-frame (cnt=5, COUNT=3) → all outputs return to reset values asynchronously; after release no TX_START until new write.
- With `TX_FEEDER_ALMOST_FULL_EN`, DEPTH=8: write 6 bytes while blocked → ALMOST_FULL rises on 6th write edge, falls on the pop leaving COUNT=5.

Source files
------------

// File: rtl/tx_feeder_pkg.sv
// ============================================================================
// Module      : tx_feeder_pkg
// Description : Shared UART constants and feeder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_feeder_pkg;

  // Transmitter byte width and frame length (start + 8 data + parity + stop).
  localparam int DATA_WIDTH     = 8;
  localparam int UART_FRAME_LEN = 11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } feeder_state_e;

endpackage

`default_nettype wire

// File: rtl/tx_feeder_sync_fifo.sv
// ============================================================================
// Module      : tx_feeder_sync_fifo
// Description : Synchronous FIFO with wrap-bit pointers and registered overflow
//               pulse. Optional ALMOST_FULL under TX_FEEDER_ALMOST_FULL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_feeder_sync_fifo
  import tx_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DATA_WIDTH
`ifdef TX_FEEDER_ALMOST_FULL_EN
  , parameter int AF_LEVEL = DEPTH - 2
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef TX_FEEDER_ALMOST_FULL_EN
  , output logic                   almost_full
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // A write seen while full is dropped even if a pop frees a slot this edge.
  always_comb begin
    push       = wr_en && !full;
    pop        = rd_en && !empty;
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    overflow_d = wr_en && full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign overflow = overflow_q;

`ifdef TX_FEEDER_ALMOST_FULL_EN
  logic        almost_full_q, almost_full_d;
  logic [AW:0] count_d;

  always_comb begin
    count_d       = wr_ptr_d - rd_ptr_d;
    almost_full_d = (int'(count_d) >= AF_LEVEL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign almost_full = almost_full_q;
`endif

endmodule

`default_nettype wire

// File: rtl/tx_feeder.sv
// ============================================================================
// Module      : tx_feeder
// Description : FIFO-buffered launch sequencer for the UART transmitter; one
//               TX_START strobe per frame, spaced FRAME_LEN+IDLE_GAP cycles.
//               Optional ALMOST_FULL output under TX_FEEDER_ALMOST_FULL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_feeder
  import tx_feeder_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = UART_FRAME_LEN,
  parameter int IDLE_GAP  = 1
`ifdef TX_FEEDER_ALMOST_FULL_EN
  , parameter int AF_LEVEL = DEPTH - 2
`endif
) (
  input  logic                    TX_CLK,
  input  logic                    TX_RST_N,
  input  logic                    WR_EN,
  input  logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic [$clog2(DEPTH):0]  COUNT,
  output logic                    OVERFLOW,
  output logic                    BUSY,
  output logic [DATA_WIDTH-1:0]   DATA_IN,
  output logic                    TX_START
`ifdef TX_FEEDER_ALMOST_FULL_EN
  , output logic                  ALMOST_FULL
`endif
);

  localparam int PERIOD = FRAME_LEN + IDLE_GAP;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(PERIOD - 1);

  feeder_state_e         state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic                  tx_start_q, tx_start_d;
  logic                  launch;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_empty;

  tx_feeder_sync_fifo #(
    .DEPTH       (DEPTH),
    .WIDTH       (DATA_WIDTH)
`ifdef TX_FEEDER_ALMOST_FULL_EN
    , .AF_LEVEL  (AF_LEVEL)
`endif
  ) u_fifo (
    .clk         (TX_CLK),
    .rst_n       (TX_RST_N),
    .wr_en       (WR_EN),
    .wr_data     (WR_DATA),
    .rd_en       (launch),
    .rd_data     (fifo_head),
    .full        (FULL),
    .empty       (fifo_empty),
    .count       (COUNT),
    .overflow    (OVERFLOW)
`ifdef TX_FEEDER_ALMOST_FULL_EN
    , .almost_full (ALMOST_FULL)
`endif
  );

  // cnt reaching zero marks the last cycle of the frame plus its idle gap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_in_d  = data_in_q;
    tx_start_d = 1'b0;
    launch     = !fifo_empty && ((state_q == ST_IDLE) || (cnt_q == '0));

    if (launch) begin
      data_in_d  = fifo_head;
      tx_start_d = 1'b1;
      cnt_d      = CNT_RELOAD;
      state_d    = ST_BUSY;
    end else if (state_q == ST_BUSY) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge TX_CLK or negedge TX_RST_N) begin
    if (!TX_RST_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      data_in_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_in_q  <= data_in_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign EMPTY    = fifo_empty;
  assign BUSY     = (state_q == ST_BUSY);
  assign DATA_IN  = data_in_q;
  assign TX_START = tx_start_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_feeder.sv
// ============================================================================
// Module      : tb_tx_feeder
// Description : Scoreboard bench for tx_feeder; a queue-based reference model
//               predicts launches, occupancy and flags from random writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_feeder;

  localparam int DEPTH     = 8;
  localparam int FRAME_LEN = 11;
  localparam int IDLE_GAP  = 1;
  localparam int PERIOD    = FRAME_LEN + IDLE_GAP;
  localparam int CNTW      = $clog2(DEPTH) + 1;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [7:0]      wr_data = 8'h00;
  logic            full, empty, overflow, busy, tx_start;
  logic [CNTW-1:0] count;
  logic [7:0]      data_in;
`ifdef TX_FEEDER_ALMOST_FULL_EN
  logic            almost_full;
`endif

  always #5 clk = ~clk;

  tx_feeder #(
    .DEPTH     (DEPTH),
    .FRAME_LEN (FRAME_LEN),
    .IDLE_GAP  (IDLE_GAP)
  ) dut (
    .TX_CLK    (clk),
    .TX_RST_N  (rst_n),
    .WR_EN     (wr_en),
    .WR_DATA   (wr_data),
    .FULL      (full),
    .EMPTY     (empty),
    .COUNT     (count),
    .OVERFLOW  (overflow),
    .BUSY      (busy),
    .DATA_IN   (data_in),
    .TX_START  (tx_start)
`ifdef TX_FEEDER_ALMOST_FULL_EN
    , .ALMOST_FULL (almost_full)
`endif
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } launch_t;

  launch_t    exp_q[$];
  logic [7:0] pend[$];
  launch_t    e_front;
  int         cyc         = 0;
  int         last_launch = 0;
  int         sz          = 0;
  bit         launched    = 1'b0;
  bit         ovf_m       = 1'b0;
  logic [7:0] data_model  = 8'h00;
  int         n_cmp       = 0;
  int         n_err       = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, expv, cyc, $time);
    end
  endtask

  // Reference model: launches happen at the earliest edge where the queue is
  // non-empty and at least PERIOD edges have passed since the previous launch.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend.delete();
        exp_q.delete();
        launched    = 1'b0;
        last_launch = 0;
        data_model  = 8'h00;
        ovf_m       = 1'b0;
      end else begin
        cyc++;
        sz = pend.size();
        if (sz > 0 && (!launched || cyc >= last_launch + PERIOD)) begin
          data_model  = pend.pop_front();
          launched    = 1'b1;
          last_launch = cyc;
          exp_q.push_back('{data_model, cyc});
        end
        ovf_m = wr_en && (sz == DEPTH);
        if (wr_en && sz < DEPTH) pend.push_back(wr_data);
      end
    end
  end

  // Monitor: compares the DUT every falling edge against the model state.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e_front = exp_q.pop_front();
        chk("tx_start_launch", int'(tx_start), 1);
        chk("launch_data", int'(data_in), int'(e_front.data));
      end else begin
        chk("tx_start_quiet", int'(tx_start), 0);
      end
      chk("data_in_hold", int'(data_in), int'(data_model));
      chk("count", int'(count), pend.size());
      chk("full", int'(full), int'(pend.size() == DEPTH));
      chk("empty", int'(empty), int'(pend.size() == 0));
      chk("overflow", int'(overflow), int'(ovf_m));
      chk("busy", int'(busy), int'(launched && (cyc < last_launch + PERIOD)));
`ifdef TX_FEEDER_ALMOST_FULL_EN
      chk("almost_full", int'(almost_full), int'(pend.size() >= DEPTH - 2));
`endif
    end
  end

  task automatic step(input bit en, input logic [7:0] d);
    @(negedge clk);
    wr_en   = en;
    wr_data = d;
  endtask

  initial begin
    repeat (3) step(1'b0, 8'h00);
    rst_n = 1'b1;

    // Quiet period after reset.
    repeat (50) step(1'b0, 8'h00);

    // Single byte into an idle block.
    step(1'b1, 8'hA5);
    repeat (20) step(1'b0, 8'h00);

    // Short burst, back-to-back launches.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i));
    repeat (60) step(1'b0, 8'h00);

    // Fill behind an in-flight frame until writes are dropped.
    for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom_range(0, 255)));

    // Heavy then light random traffic, exercising pop+write at all levels.
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 1) == 0), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)));
    repeat (PERIOD * (DEPTH + 2)) step(1'b0, 8'h00);

    // Reset in the middle of a frame with bytes still queued.
    for (int i = 0; i < 4; i++) step(1'b1, 8'h30 + 8'(i));
    for (int i = 0; i < 20 && !(launched && cyc == last_launch + 6); i++)
      step(1'b0, 8'h00);
    chk("pre_reset_count", int'(count), 3);
    chk("pre_reset_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_full", int'(full), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data_in", int'(data_in), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    repeat (2) step(1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (20) step(1'b0, 8'h00);

    // One more byte after reset to confirm normal operation resumes.
    step(1'b1, 8'h5A);
    repeat (20) step(1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
